// File: rtl/dual_issue_split.sv
// ID->EX issue register for the dual-issue pipe. A pair with an intra-pair RAW
// hazard is split: slot0 issues first, then slot1 issues from a hold buffer in lane0.
module dual_issue_split #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_v0,
    input  logic             id_v1,
    input  logic [XLEN-1:0]  id_pc_0,
    input  logic [XLEN-1:0]  id_pc_1,
    input  logic [XLEN-1:0]  id_inst_0,
    input  logic [XLEN-1:0]  id_inst_1,
    input  logic [4:0]       id_rd_0,
    input  logic [4:0]       id_rd_1,
    input  logic             id_rdwen_0,
    input  logic             id_rdwen_1,
    input  logic             stallex,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             id_ready,
    output logic             ex_v0,
    output logic             ex_v1,
    output logic [XLEN-1:0]  ex_pc_0,
    output logic [XLEN-1:0]  ex_pc_1,
    output logic [XLEN-1:0]  ex_inst_0,
    output logic [XLEN-1:0]  ex_inst_1,
    output logic [4:0]       ex_rd_0,
    output logic [4:0]       ex_rd_1,
    output logic             ex_rdwen_0,
    output logic             ex_rdwen_1,
    output logic             split_busy,
    output logic [CNT_W-1:0] split_cnt
);

    typedef enum logic {PASS, SPLIT} state_t;

    state_t            state;
    logic              hold_valid;
    logic [XLEN-1:0]   hold_pc;
    logic [XLEN-1:0]   hold_inst;
    logic [4:0]        hold_rd;
    logic              hold_rdwen;
    logic              acc;
    logic              do_split;

    // The hazard flag only matters when both slots of the accepted pair are real.
    assign id_ready   = ex_ready & (state == PASS) & ~flush;
    assign acc        = id_valid & id_ready;
    assign do_split   = acc & stallex & id_v0 & id_v1;
    assign split_busy = (state == SPLIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= PASS;
            ex_v0      <= 1'b0;
            ex_v1      <= 1'b0;
            ex_pc_0    <= '0;
            ex_pc_1    <= '0;
            ex_inst_0  <= '0;
            ex_inst_1  <= '0;
            ex_rd_0    <= '0;
            ex_rd_1    <= '0;
            ex_rdwen_0 <= 1'b0;
            ex_rdwen_1 <= 1'b0;
            hold_valid <= 1'b0;
            hold_pc    <= '0;
            hold_inst  <= '0;
            hold_rd    <= '0;
            hold_rdwen <= 1'b0;
            split_cnt  <= '0;
        end else if (flush) begin
            ex_v0      <= 1'b0;
            ex_v1      <= 1'b0;
            hold_valid <= 1'b0;
            state      <= PASS;
        end else begin
            case (state)
                PASS: begin
                    if (ex_ready) begin
                        ex_v0 <= acc & id_v0;
                        ex_v1 <= acc & id_v1 & ~do_split;
                        if (acc) begin
                            ex_pc_0    <= id_pc_0;
                            ex_inst_0  <= id_inst_0;
                            ex_rd_0    <= id_rd_0;
                            ex_rdwen_0 <= id_rdwen_0;
                            ex_pc_1    <= id_pc_1;
                            ex_inst_1  <= id_inst_1;
                            ex_rd_1    <= id_rd_1;
                            ex_rdwen_1 <= id_rdwen_1;
                        end
                        if (do_split) begin
                            hold_valid <= 1'b1;
                            hold_pc    <= id_pc_1;
                            hold_inst  <= id_inst_1;
                            hold_rd    <= id_rd_1;
                            hold_rdwen <= id_rdwen_1;
                            state      <= SPLIT;
                            if (split_cnt != '1)
                                split_cnt <= split_cnt + CNT_W'(1);
                        end
                    end
                end
                SPLIT: begin
                    // The held slot1 always drains through lane0.
                    if (ex_ready) begin
                        ex_v0      <= hold_valid;
                        ex_v1      <= 1'b0;
                        ex_pc_0    <= hold_pc;
                        ex_inst_0  <= hold_inst;
                        ex_rd_0    <= hold_rd;
                        ex_rdwen_0 <= hold_rdwen;
                        hold_valid <= 1'b0;
                        state      <= PASS;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_issue_split.sv
// Self-checking bench for dual_issue_split: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a queue-based model.
module tb_dual_issue_split;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rdwen;
    } slot_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        d_id_valid = 1'b0;
    logic        d_v0 = 1'b0;
    logic        d_v1 = 1'b0;
    slot_t       d_slot0 = '0;
    slot_t       d_slot1 = '0;
    logic        d_stallex = 1'b0;
    logic        d_ex_ready = 1'b0;
    logic        d_flush = 1'b0;

    logic             id_ready, ex_v0, ex_v1, split_busy;
    logic [XLEN-1:0]  ex_pc_0, ex_pc_1, ex_inst_0, ex_inst_1;
    logic [4:0]       ex_rd_0, ex_rd_1;
    logic             ex_rdwen_0, ex_rdwen_1;
    logic [CNT_W-1:0] split_cnt;

    int checks = 0;
    int failures = 0;

    dual_issue_split #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .id_valid   (d_id_valid),
        .id_v0      (d_v0),
        .id_v1      (d_v1),
        .id_pc_0    (d_slot0.pc),
        .id_pc_1    (d_slot1.pc),
        .id_inst_0  (d_slot0.inst),
        .id_inst_1  (d_slot1.inst),
        .id_rd_0    (d_slot0.rd),
        .id_rd_1    (d_slot1.rd),
        .id_rdwen_0 (d_slot0.rdwen),
        .id_rdwen_1 (d_slot1.rdwen),
        .stallex    (d_stallex),
        .ex_ready   (d_ex_ready),
        .flush      (d_flush),
        .id_ready   (id_ready),
        .ex_v0      (ex_v0),
        .ex_v1      (ex_v1),
        .ex_pc_0    (ex_pc_0),
        .ex_pc_1    (ex_pc_1),
        .ex_inst_0  (ex_inst_0),
        .ex_inst_1  (ex_inst_1),
        .ex_rd_0    (ex_rd_0),
        .ex_rd_1    (ex_rd_1),
        .ex_rdwen_0 (ex_rdwen_0),
        .ex_rdwen_1 (ex_rdwen_1),
        .split_busy (split_busy),
        .split_cnt  (split_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: what EX should see, with split-off slot1s waiting in a queue.
    bit    m_v0, m_v1;
    slot_t m_lane0, m_lane1;
    slot_t m_pend[$];
    int    m_cnt;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_v0 = 0;
            m_v1 = 0;
            m_pend.delete();
            m_cnt = 0;
        end else if (d_flush) begin
            m_v0 = 0;
            m_v1 = 0;
            m_pend.delete();
        end else if (d_ex_ready) begin
            if (m_pend.size() != 0) begin
                m_lane0 = m_pend.pop_front();
                m_v0 = 1;
                m_v1 = 0;
            end else if (!d_id_valid) begin
                m_v0 = 0;
                m_v1 = 0;
            end else if (d_stallex && d_v0 && d_v1) begin
                m_lane0 = d_slot0;
                m_v0 = 1;
                m_v1 = 0;
                m_pend.push_back(d_slot1);
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end else begin
                m_lane0 = d_slot0;
                m_lane1 = d_slot1;
                m_v0 = d_v0;
                m_v1 = d_v1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle out of reset, the DUT must match the model on all meaningful outputs.
    always @(negedge clock) begin
        if (reset) begin
            checkOutput("id_ready", 32'(id_ready),
                        32'(d_ex_ready && (m_pend.size() == 0) && !d_flush));
            checkOutput("ex_v0", 32'(ex_v0), 32'(m_v0));
            checkOutput("ex_v1", 32'(ex_v1), 32'(m_v1));
            checkOutput("split_busy", 32'(split_busy), 32'(m_pend.size() != 0));
            checkOutput("split_cnt", 32'(split_cnt), 32'(m_cnt));
            if (m_v0) begin
                checkOutput("lane0_pc", ex_pc_0, m_lane0.pc);
                checkOutput("lane0_inst", ex_inst_0, m_lane0.inst);
                checkOutput("lane0_rd", {26'd0, ex_rdwen_0, ex_rd_0}, {26'd0, m_lane0.rdwen, m_lane0.rd});
            end
            if (m_v1) begin
                checkOutput("lane1_pc", ex_pc_1, m_lane1.pc);
                checkOutput("lane1_inst", ex_inst_1, m_lane1.inst);
                checkOutput("lane1_rd", {26'd0, ex_rdwen_1, ex_rd_1}, {26'd0, m_lane1.rdwen, m_lane1.rd});
            end
        end
    end

    task automatic applyStimulus(input bit valid, input bit v0, input bit v1,
                                 input logic [31:0] pc0, input logic [31:0] pc1,
                                 input bit stall, input bit ready, input bit fl);
        @(posedge clock);
        #2;
        d_id_valid = valid;
        d_v0 = v0;
        d_v1 = v1;
        d_slot0 = '{pc: pc0, inst: $urandom, rd: 5'($urandom), rdwen: 1'($urandom)};
        d_slot1 = '{pc: pc1, inst: $urandom, rd: 5'($urandom), rdwen: 1'($urandom)};
        d_stallex = stall;
        d_ex_ready = ready;
        d_flush = fl;
    endtask

    task automatic idle(input bit ready);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, ready, 0);
    endtask

    task automatic splitPair();
        applyStimulus(1, 1, 1, 32'h100, 32'h104, 1, 1, 0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("reset_v0", 32'(ex_v0), 32'd0);
        checkOutput("reset_pc0", ex_pc_0, 32'd0);
        checkOutput("reset_busy", 32'(split_busy), 32'd0);
        checkOutput("reset_cnt", 32'(split_cnt), 32'd0);

        // No hazard: both slots issue together.
        applyStimulus(1, 1, 1, 32'h100, 32'h104, 0, 1, 0);
        #1 checkOutput("nohaz_id_ready", 32'(id_ready), 32'd1);
        idle(1);
        @(negedge clock);
        checkOutput("nohaz_v0", 32'(ex_v0), 32'd1);
        checkOutput("nohaz_v1", 32'(ex_v1), 32'd1);
        checkOutput("nohaz_pc0", ex_pc_0, 32'h100);
        checkOutput("nohaz_pc1", ex_pc_1, 32'h104);

        // Hazard split.
        splitPair();
        idle(1);
        @(negedge clock);
        checkOutput("split1_v0", 32'(ex_v0), 32'd1);
        checkOutput("split1_pc0", ex_pc_0, 32'h100);
        checkOutput("split1_v1", 32'(ex_v1), 32'd0);
        checkOutput("split1_busy", 32'(split_busy), 32'd1);
        checkOutput("split1_id_ready", 32'(id_ready), 32'd0);
        idle(1);
        @(negedge clock);
        checkOutput("split2_v0", 32'(ex_v0), 32'd1);
        checkOutput("split2_pc0", ex_pc_0, 32'h104);
        checkOutput("split2_busy", 32'(split_busy), 32'd0);
        checkOutput("split2_cnt", 32'(split_cnt), 32'd1);

        // Back-pressure while split.
        splitPair();
        for (int i = 0; i < 3; i++) begin
            idle(0);
            @(negedge clock);
            checkOutput("bp_pc0", ex_pc_0, 32'h100);
            checkOutput("bp_busy", 32'(split_busy), 32'd1);
        end
        idle(1);
        idle(1);
        @(negedge clock);
        checkOutput("bp_release_pc0", ex_pc_0, 32'h104);
        checkOutput("bp_release_v0", 32'(ex_v0), 32'd1);
        checkOutput("bp_cnt", 32'(split_cnt), 32'd2);

        // Single-valid pair ignores stallex.
        applyStimulus(1, 1, 0, 32'h200, 32'h204, 1, 1, 0);
        idle(1);
        @(negedge clock);
        checkOutput("single_v0", 32'(ex_v0), 32'd1);
        checkOutput("single_v1", 32'(ex_v1), 32'd0);
        checkOutput("single_busy", 32'(split_busy), 32'd0);
        checkOutput("single_cnt", 32'(split_cnt), 32'd2);

        // Flush during SPLIT with ex_ready low.
        splitPair();
        idle(0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 1);
        #1 checkOutput("flush_id_ready_low", 32'(id_ready), 32'd0);
        idle(1);
        @(negedge clock);
        checkOutput("flush_v0", 32'(ex_v0), 32'd0);
        checkOutput("flush_v1", 32'(ex_v1), 32'd0);
        checkOutput("flush_busy", 32'(split_busy), 32'd0);
        checkOutput("flush_id_ready", 32'(id_ready), 32'd1);
        idle(1);
        idle(1);
        @(negedge clock);
        checkOutput("flush_no_issue", 32'(ex_v0), 32'd0);
        checkOutput("flush_cnt", 32'(split_cnt), 32'd3);

        // Flush coinciding with a would-be split acceptance.
        applyStimulus(1, 1, 1, 32'h300, 32'h304, 1, 1, 1);
        idle(1);
        @(negedge clock);
        checkOutput("flushacc_busy", 32'(split_busy), 32'd0);
        checkOutput("flushacc_v0", 32'(ex_v0), 32'd0);
        checkOutput("flushacc_cnt", 32'(split_cnt), 32'd3);

        // Asynchronous reset between edges while split.
        splitPair();
        idle(0);
        @(negedge clock);
        checkOutput("prereset_busy", 32'(split_busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("areset_v0", 32'(ex_v0), 32'd0);
        checkOutput("areset_v1", 32'(ex_v1), 32'd0);
        checkOutput("areset_busy", 32'(split_busy), 32'd0);
        checkOutput("areset_cnt", 32'(split_cnt), 32'd0);
        #1 reset = 1'b1;
        idle(1);
        idle(1);
        @(negedge clock);
        checkOutput("areset_discard", 32'(ex_v0), 32'd0);

        // Counter saturation.
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            splitPair();
            idle(1);
        end
        idle(1);
        @(negedge clock);
        checkOutput("sat_cnt", 32'(split_cnt), 32'(CNT_MAX));

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 9),
                          ($urandom_range(0, 9) < 8), $urandom & 32'hFFFF_FFFC,
                          $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 9) < 4),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end
        idle(1);
        idle(1);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_issue_split.md
Name: dual_issue_split

Overview:
- ID→EX issue register for the dual-issue pipe. Consumes the intra-pair RAW-hazard flag (stallex) produced by the hazard detector that sits beside decode.
- When the pair is hazard-free, both slots issue together.
- When stallex=1, the pair is split: slot0 issues first and slot1 issues on the next EX-accepting cycle, with decode back-pressured in between.

Parameters:
- XLEN, 32, width of pc/inst fields
- CNT_W, 16, width of the saturating split-event counter

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- id_valid  in  1  decode presents a pair this cycle
- id_v0, id_v1  in  1 each  per-slot valid within the pair
- id_pc_0, id_pc_1  in  XLEN each  slot PCs
- id_inst_0, id_inst_1  in  XLEN each  slot instruction words
- id_rd_0, id_rd_1  in  5 each  destination registers
- id_rdwen_0, id_rdwen_1  in  1 each  register write enables
- stallex  in  1  intra-pair hazard flag (slot0 rd feeds slot1 rs1/rs2)
- ex_ready  in  1  EX accepts the issue register contents this cycle
- flush  in  1  redirect; kill all in-flight state
- id_ready  out  1  decode may advance; combinational
- ex_v0, ex_v1  out  1 each  issued slot valids (registered)
- ex_pc_0, ex_pc_1, ex_inst_0, ex_inst_1  out  XLEN each  issued fields
- ex_rd_0, ex_rd_1  out  5 each; ex_rdwen_0, ex_rdwen_1  out  1 each
- split_busy  out  1  high while state=SPLIT
- split_cnt  out  CNT_W  saturating count of split events

Behaviour:
- Reset (reset=0, asynchronous): state=PASS; ex_v0=ex_v1=0; all ex_* data=0; hold buffer valid=0; split_cnt=0.
- id_ready = ex_ready & (state==PASS) & ~flush.
- Accept condition: acc = id_valid & id_ready.
- State PASS:
  - acc & ~(stallex & id_v0 & id_v1): at the next edge, lane0←slot0 and lane1←slot1 (valids copied from id_v0/id_v1). Stay in PASS.
  - acc & stallex & id_v0 & id_v1: at the next edge, lane0←slot0 and ex_v1=0. Hold buffer←slot1. state→SPLIT. split_cnt+1, saturating at 2^CNT_W−1.
  - stallex is ignored when either slot is invalid.
  - ex_ready=1 with no acc: ex_v0=ex_v1=0 (bubble).
  - ex_ready=0: all ex_* outputs hold their values.
- State SPLIT:
  - ex_ready=1: at the next edge, lane0←hold buffer, ex_v0=1, ex_v1=0, hold valid cleared, state→PASS.
  - ex_ready=0: everything holds and the state stays SPLIT.
  - The held instruction always issues in lane0.
- Latency: 1 cycle from acc to ex_v*. A split pair occupies 2 EX-accepting cycles.
- Issue order: slot0 is never issued after slot1. In SPLIT, no new pair is accepted.
- flush:
  - Highest priority, and takes effect even when ex_ready=0.
  - Next edge: ex_v0=ex_v1=0, hold valid=0, state→PASS.
  - split_cnt is not cleared.
  - flush in the same cycle as a split acceptance: no split occurs and no count is taken.
- Data fields of invalid lanes are don't-care but must not be X after reset.
- Reset asserted mid-SPLIT: immediate return to the reset state; the held instruction is discarded.

Test Plan:
- No hazard: pair pc 0x100/0x104, stallex=0, ex_ready=1 → next cycle ex_v0=ex_v1=1 with pcs 0x100/0x104; id_ready stays 1.
- Hazard split: rd_0=5 with rs1_1=5, stallex=1 → cycle+1: ex_v0=1 pc 0x100, ex_v1=0, split_busy=1, id_ready=0. Cycle+2: ex_v0=1 pc 0x104 in lane0, split_busy=0, split_cnt=1.
- Back-pressure in SPLIT: hold ex_ready=0 for 3 cycles after the split → outputs stay at pc 0x100 and the state stays SPLIT. Release → pc 0x104 issues 1 cycle later.
- Single-valid pair with stallex=1 (id_v1=0) → no split: ex_v0=1, ex_v1=0, split_cnt unchanged.
- Flush during SPLIT with ex_ready=0 → next cycle ex_v0=ex_v1=0, split_busy=0, id_ready=1; the held pc 0x104 is never issued.
- Async reset pulsed mid-SPLIT between clock edges → outputs cleared immediately without a clock edge. Also: drive 2^16 consecutive splits → split_cnt saturates at 0xFFFF.
